// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency-meter counting core.
package freq_meter_pkg;

  localparam int BCD_W = 4;
  localparam logic MODE_FREQ = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  // Select-bus width for n reference inputs; never narrower than one bit.
  function automatic int tsel_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9, rolls over with a carry to the next decade.
module bcd_digit
  import freq_meter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_carry
);

  localparam logic [BCD_W-1:0] DIG_MAX = BCD_W'(9);

  logic [BCD_W-1:0] r_digit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_inc) begin
      r_digit <= (r_digit == DIG_MAX) ? '0 : r_digit + 1'b1;
    end
  end

  assign o_digit = r_digit;
  assign o_carry = i_inc & (r_digit == DIG_MAX);

endmodule

// File: rtl/bcd_count_core.sv
// Gated BCD event counter with store register and auto-range hints for the
// frequency meter; CPx is sampled on CP, never used as a clock.
module bcd_count_core
  import freq_meter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int NREF        = 3,
  parameter int SYNC_STAGES = 2,
  localparam int TSEL_W     = tsel_w(NREF)
)(
  input  logic                    CP,
  input  logic                    RST,
  input  logic                    CPx,
  input  logic [NREF-1:0]         ref_tick,
  input  logic [TSEL_W-1:0]       T_sel,
  input  logic                    measure_mode,
  input  logic                    C_Enable,
  input  logic                    C_Store,
  input  logic                    C_Clear,
  output logic [BCD_W*DIGITS-1:0] BCD,
  output logic                    overflow,
  output logic                    range_up,
  output logic                    range_down,
  output logic                    store_valid
);

  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_sync_prev;
  logic                    r_cpx_edge;
  logic                    w_ref_sel;
  logic                    w_event;
  logic [DIGITS:0]         w_carry;
  logic [BCD_W*DIGITS-1:0] w_work;
  logic                    r_ovf_work;
  logic [BCD_W*DIGITS-1:0] r_bcd;
  logic                    r_overflow;
  logic                    r_range_up;
  logic                    r_range_down;
  logic                    r_store_valid;

  // Stage: CPx synchroniser and registered rising-edge pulse
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_cpx_edge  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], CPx};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_cpx_edge  <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    end
  end

  // Out-of-range selects match no input and leave the event low.
  always_comb begin
    w_ref_sel = 1'b0;
    for (int i = 0; i < NREF; i++) begin
      if (T_sel == TSEL_W'(i)) w_ref_sel = ref_tick[i];
    end
  end

  assign w_event    = (measure_mode == MODE_PERIOD) ? w_ref_sel : r_cpx_edge;
  assign w_carry[0] = w_event & C_Enable & ~C_Clear;

  // Stage: working counter, decades chained through their carries
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .i_clk   (CP),
      .i_rst   (RST),
      .i_inc   (w_carry[k]),
      .i_clear (C_Clear),
      .o_digit (w_work[k*BCD_W +: BCD_W]),
      .o_carry (w_carry[k+1])
    );
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_ovf_work <= 1'b0;
    end else if (C_Clear) begin
      r_ovf_work <= 1'b0;
    end else if (w_carry[DIGITS]) begin
      r_ovf_work <= 1'b1;
    end
  end

  // Stage: store register samples the pre-update working state
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      r_bcd         <= '0;
      r_overflow    <= 1'b0;
      r_range_up    <= 1'b0;
      r_range_down  <= 1'b0;
      r_store_valid <= 1'b0;
    end else begin
      r_store_valid <= C_Store;
      if (C_Store) begin
        r_bcd        <= w_work;
        r_overflow   <= r_ovf_work;
        r_range_up   <= r_ovf_work;
        r_range_down <= ~r_ovf_work & (w_work[BCD_W*DIGITS-1 -: BCD_W] == '0);
      end
    end
  end

  assign BCD         = r_bcd;
  assign overflow    = r_overflow;
  assign range_up    = r_range_up;
  assign range_down  = r_range_down;
  assign store_valid = r_store_valid;

endmodule

// File: tb/tb_bcd_count_core.sv
// Randomised bench for bcd_count_core: three instances (4, 6 and 2 decades)
// share one stimulus and are checked against an arithmetic count model.
module tb_bcd_count_core;

  logic        CP = 1'b0;
  logic        RST;
  logic        CPx;
  logic [2:0]  ref_tick;
  logic [1:0]  T_sel;
  logic        measure_mode, C_Enable, C_Store, C_Clear;
  logic [15:0] bcd4;
  logic [23:0] bcd6;
  logic [7:0]  bcd2;
  logic        ovf4, ru4, rd4, sv4;
  logic        ovf6, ru6, rd6, sv6;
  logic        ovf2, ru2, rd2, sv2;

  always #5 CP = ~CP;

  bcd_count_core #(.DIGITS(4), .NREF(3), .SYNC_STAGES(2)) u_d4 (
    .CP(CP), .RST(RST), .CPx(CPx), .ref_tick(ref_tick), .T_sel(T_sel),
    .measure_mode(measure_mode), .C_Enable(C_Enable), .C_Store(C_Store), .C_Clear(C_Clear),
    .BCD(bcd4), .overflow(ovf4), .range_up(ru4), .range_down(rd4), .store_valid(sv4));

  bcd_count_core #(.DIGITS(6), .NREF(3), .SYNC_STAGES(3)) u_d6 (
    .CP(CP), .RST(RST), .CPx(CPx), .ref_tick(ref_tick), .T_sel(T_sel),
    .measure_mode(measure_mode), .C_Enable(C_Enable), .C_Store(C_Store), .C_Clear(C_Clear),
    .BCD(bcd6), .overflow(ovf6), .range_up(ru6), .range_down(rd6), .store_valid(sv6));

  bcd_count_core #(.DIGITS(2), .NREF(3), .SYNC_STAGES(2)) u_d2 (
    .CP(CP), .RST(RST), .CPx(CPx), .ref_tick(ref_tick), .T_sel(T_sel),
    .measure_mode(measure_mode), .C_Enable(C_Enable), .C_Store(C_Store), .C_Clear(C_Clear),
    .BCD(bcd2), .overflow(ovf2), .range_up(ru2), .range_down(rd2), .store_valid(sv2));

  logic [27:0] obs [3];
  assign obs[0] = {8'h00, bcd4, ovf4, ru4, rd4, sv4};
  assign obs[1] = {bcd6, ovf6, ru6, rd6, sv6};
  assign obs[2] = {16'h0000, bcd2, ovf2, ru2, rd2, sv2};

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: plain integer count modulo 10^D with a sticky wrap flag.
  int          ndig [3] = '{4, 6, 2};
  longint      mcnt [3];
  bit          movf [3];
  logic [23:0] ebcd [3];
  bit          eovf [3];
  bit          erd  [3];

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [23:0] to_bcd(input longint v, input int d);
    logic [23:0] r = '0;
    for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [27:0] exp_vec(input int i, input bit sv);
    return {ebcd[i], eovf[i], eovf[i], erd[i], sv};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; movf[i] = 0; ebcd[i] = '0; eovf[i] = 0; erd[i] = 0;
    end
  endtask

  task automatic model_event();
    for (int i = 0; i < 3; i++) begin
      if (mcnt[i] == pow10(ndig[i]) - 1) begin
        mcnt[i] = 0; movf[i] = 1;
      end else begin
        mcnt[i]++;
      end
    end
  endtask

  task automatic model_store();
    for (int i = 0; i < 3; i++) begin
      ebcd[i] = to_bcd(mcnt[i], ndig[i]);
      eovf[i] = movf[i];
      erd[i]  = !movf[i] && (mcnt[i] < pow10(ndig[i] - 1));
    end
  endtask

  // Drive one CP cycle (called at posedge+1) and advance the model for that edge.
  task automatic step(input bit st, input bit cl, input bit en, input bit md,
                      input bit [1:0] ts, input bit [2:0] rt);
    bit ev;
    C_Store = st; C_Clear = cl; C_Enable = en; measure_mode = md;
    T_sel = ts; ref_tick = rt;
    ev = md && ((ts < 3) ? rt[ts] : 1'b0);
    if (st) model_store();
    if (cl) begin
      for (int i = 0; i < 3; i++) begin mcnt[i] = 0; movf[i] = 0; end
    end else if (ev && en) begin
      model_event();
    end
    @(posedge CP); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CP);
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b0))
        $display("FAIL reset d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b0));
      else n_pass++;
    end
    RST = 1'b0;
    @(posedge CP); #1;
  endtask

  task automatic test_freq();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    #3;
    repeat (1234) begin
      CPx = 1'b1; #25;
      CPx = 1'b0; #25;
    end
    repeat (10) @(posedge CP);
    #1;
    for (int n = 0; n < 1234; n++) model_event();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL freq_store d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b0))
        $display("FAIL freq_hold d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_period();
    int pulses = 0;
    bit [2:0] rt;
    step(0, 1, 0, 1, 2, 0);
    while (pulses < 57) begin
      rt = 3'($urandom_range(0, 7));
      if (rt[2]) pulses++;
      step(0, 0, 1, 1, 2, rt);
    end
    step(0, 0, 0, 1, 2, 0);
    step(1, 0, 0, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL period_sel2 d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    for (int n = 0; n < 40; n++) step(0, 0, 1, 1, 3, 3'($urandom_range(0, 7)));
    step(1, 0, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL period_sel3 d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    step(0, 1, 0, 1, 0, 0);
    for (int n = 0; n < 10000; n++) step(0, 0, 1, 1, 0, 3'b001);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL ovf_store d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    step(0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL ovf_cleared d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_store_clear();
    step(0, 1, 0, 1, 0, 0);
    for (int n = 0; n < 42; n++) step(0, 0, 1, 1, 0, 3'b001);
    step(1, 1, 1, 1, 0, 3'b001);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL store_clear d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL after_clear d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_store_event();
    step(0, 1, 0, 1, 1, 0);
    for (int n = 0; n < 99; n++) step(0, 0, 1, 1, 1, 3'b010);
    step(1, 0, 1, 1, 1, 3'b010);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL store_event d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL carry_100 d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 1, 0, 0);
    for (int n = 0; n < 5; n++) step(0, 0, 1, 1, 0, 3'b001);
    step(1, 0, 1, 1, 0, 3'b001);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL pre_reset d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    for (int n = 0; n < 3; n++) step(0, 0, 1, 1, 0, 3'b001);
    #2 RST = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b0))
        $display("FAIL async_reset d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b0));
      else n_pass++;
    end
    repeat (5) @(posedge CP);
    #1;
    RST = 1'b0;
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL held_in_reset d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
    for (int n = 0; n < 7; n++) step(0, 0, 1, 1, 0, 3'b001);
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (obs[i] !== exp_vec(i, 1'b1))
        $display("FAIL resume d%0d: got %h want %h", ndig[i], obs[i], exp_vec(i, 1'b1));
      else n_pass++;
    end
  endtask

  initial begin
    RST = 1'b1; CPx = 1'b0; ref_tick = '0; T_sel = '0;
    measure_mode = 1'b0; C_Enable = 1'b0; C_Store = 1'b0; C_Clear = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_freq();
    test_period();
    test_overflow();
    test_store_clear();
    test_store_event();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_count_core.md
# bcd_count_core

Parametrised counting core for the digital frequency meter. It counts either edges of the signal under test (frequency mode) or ticks of a selectable reference timebase (period mode) into a DIGITS-wide BCD counter. The core sits under the gate/control FSM, which drives C_Enable, C_Store and C_Clear, and above the display/readout logic, which consumes the stored digits, overflow and auto-range hints. Unlike the previous generation, the block is fully synchronous to one system clock: the measured signal and the reference ticks are sampled, never used as clocks.

## Interface
Parameters:
- DIGITS, 4, number of BCD decades (≥1)
- NREF, 3, number of reference tick inputs (≥1)
- SYNC_STAGES, 2, synchroniser depth for CPx (≥2)

Ports:
- CP  in  1  system clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- CPx  in  1  asynchronous signal under test
- ref_tick  in  NREF  reference ticks, one-CP-cycle pulses synchronous to CP
- T_sel  in  max(1,clog2(NREF))  reference select; values ≥ NREF select nothing
- measure_mode  in  1  0 = frequency (count CPx edges), 1 = period (count ref_tick[T_sel])
- C_Enable  in  1  count gate, level
- C_Store  in  1  store strobe, one-cycle pulse
- C_Clear  in  1  working-counter clear, one-cycle pulse
- BCD  out  4*DIGITS  stored result, digit 0 in bits [3:0]
- overflow  out  1  stored overflow flag
- range_up  out  1  stored hint: count overflowed, select coarser range
- range_down  out  1  stored hint: top decade zero, select finer range
- store_valid  out  1  one-cycle pulse, stored outputs updated

## Operation
- CPx passes through SYNC_STAGES flops; rising-edge detector yields cpx_edge (one-cycle pulse).
- event = measure_mode ? ref_tick[T_sel] : cpx_edge; T_sel ≥ NREF gives event = 0.
- Working counter work[DIGITS] and sticky ovf_work.
- Priority per cycle: C_Clear > increment. C_Clear: work ← 0, ovf_work ← 0.
- Increment when event & C_Enable & !C_Clear: decade ripple, digit 9→0 with carry to next; digit never leaves 0–9.
- All digits 9 plus increment: work wraps to 0, ovf_work ← 1 (held until C_Clear or RST).
- C_Store samples work and ovf_work as they are at that clock edge (pre-increment, pre-clear): BCD ← work, overflow ← ovf_work, range_up ← ovf_work, range_down ← !ovf_work & (work top digit == 0).
- range_up and range_down are never both 1; all stored outputs hold until next C_Store.
- measure_mode/T_sel changes take effect on the next event; keeping them stable while gated is the controller's job.
- RST: all flops including synchroniser cleared; all outputs 0 immediately.

## Timing
- CPx edge → cpx_edge: SYNC_STAGES+1 CP cycles; → work updated 1 cycle later.
- ref_tick → work updated next CP edge (no synchroniser).
- C_Store at edge n → BCD/overflow/range_* valid and store_valid = 1 after edge n; store_valid low after edge n+1.
- Simultaneous C_Store and C_Clear: stored = pre-clear value; work = 0 afterwards.
- Simultaneous C_Store and event: stored = pre-increment value.
- CPx high and low each ≥ 2 CP periods for guaranteed counting (fCPx < fCP/4).
- All outputs registered; no combinational input-to-output path.

## Structure
- Package freq_meter_pkg: BCD_W = 4, MODE_FREQ = 0, MODE_PERIOD = 1, clog2 helper for T_sel width.
- Sub-module bcd_digit: one decade, inputs inc/clear, outputs digit and carry (digit==9 & inc); instantiated DIGITS times via generate, carry chained.
- Synchroniser + edge detect inline.

## Test plan
- Freq mode, CP 100 MHz, CPx 20 MHz, gate open for exactly 1234 CPx edges, then C_Store → BCD = 0x1234, overflow = 0, range_up = 0, range_down = 0, store_valid high one cycle.
- Period mode, T_sel = 2, 57 pulses on ref_tick[2] and random pulses on ref_tick[0..1] → BCD = 0x0057, range_down = 1; T_sel = 3 → no counting.
- 10000 events at DIGITS = 4 → store gives BCD = 0x0000, overflow = 1, range_up = 1; C_Clear then store → 0x0000, overflow = 0, range_down = 1.
- work = 0x0042, C_Store and C_Clear same cycle → BCD = 0x0042; next C_Store with no events → BCD = 0x0000.
- work = 0x0099, C_Store coincident with event → BCD = 0x0099, work becomes 0x0100 (verify with next store).
- RST pulsed mid-count → all outputs 0 asynchronously, no count until release; DIGITS = 6 instance: 999999 + 1 → overflow = 1.
